minibyte_arbmux: RTL and testbench
==================================

# minibyte_arbmux

Parametrised N-channel, W-bit registered bus multiplexer with per-channel request/grant handshake, a selectable direct-select or round-robin arbitration mode, and a one-entry output register with a valid/ready handshake toward the consumer. It generalises the CPU's fixed 4:1 8-bit select muxes for places where several sources compete for one datapath, such as the fetch versus data memory port or the external I/O bus. It supports back-to-back transfers at one per cycle.

## Interface
Parameters:
- WIDTH, 8, data width of each channel and of the output.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_CH), derived localparam; width of channel indices.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- mode_in  input  1  0 = direct select (MUX_MODE_DIRECT), 1 = round-robin (MUX_MODE_RR).
- sel_in  input  SEL_W  channel index used in direct mode.
- req_in  input  NUM_CH  per-channel request (source has valid data).
- data_in  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- gnt_out  output  NUM_CH  one-hot grant; high in the cycle the channel's data is captured.
- data_out  output  WIDTH  registered selected data.
- ch_out  output  SEL_W  index of the channel that supplied data_out.
- valid_out  output  1  data_out holds an unconsumed word.
- ready_in  input  1  consumer accepts data_out this cycle.

## Operation
- Storage is two states, encoded by valid_out: EMPTY (valid_out=0) and FULL (valid_out=1).
- `can_load = !valid_out || ready_in`.
- Winner selection (combinational):
  - Direct mode: the winner is sel_in if `sel_in < NUM_CH` and req_in[sel_in]=1; otherwise there is no winner.
  - RR mode: the winner is the first requesting channel after last_ptr, searching upward and wrapping NUM_CH-1 to 0. last_ptr itself is checked last.
- `load = can_load && winner exists`. gnt_out equals onehot(winner) when load is high, else all zeros.
- On a clock edge with load high:
  - data_out ← data_in[winner].
  - ch_out ← winner.
  - valid_out ← 1.
  - last_ptr ← winner (in both modes).
- On a clock edge with `ready_in && valid_out && !load`: valid_out ← 0. data_out and ch_out hold their last values.
- In FULL with ready_in=0: data_out, ch_out and valid_out hold, and gnt_out=0.
- Source rule: a source holds req_in and its data stable until it sees its gnt_out bit. Dropping req_in before the grant is legal and simply withdraws the request.
- mode_in and sel_in are sampled only at load. Changing either while FULL has no effect on the stored word.
- ready_in while EMPTY is ignored.
- Reset values: valid_out=0, data_out=0, ch_out=0, gnt_out=0, last_ptr=NUM_CH-1 (so channel 0 wins first after reset).
- Reset asserted mid-transfer discards the held word with no grant and no handshake completion. gnt_out is forced to 0 while rst_in=1.

## Timing
- gnt_out is combinational from req_in, mode_in, sel_in, ready_in and internal state, in the same cycle the request is served.
- Latency: a request in cycle N with can_load=1 produces gnt_out in cycle N and valid_out/data_out in cycle N+1.
- Throughput: one word per cycle when ready_in is held high and requests are continuous, with no bubble on accept+load.
- RR fairness: with all NUM_CH requesting continuously, every channel is granted exactly once in any NUM_CH consecutive loads.
- No combinational path from data_in to data_out.

## Structure
- Shared package minibyte_pkg holds:
  - MUX_MODE_DIRECT = 1'b0 and MUX_MODE_RR = 1'b1.
  - A function for onehot(index).
- Sub-module minibyte_rr_pick is a combinational rotate-priority picker. Its inputs are req[NUM_CH] and last_ptr. Its outputs are found and idx[SEL_W].
- The direct path and register/handshake logic live in minibyte_arbmux.

## Test plan
- **Reset/first grant:** rst_in=1 for 2 cycles with all req_in=1 → gnt_out=0 and valid_out=0 during reset. Release reset in RR mode with ready_in=1 → gnt sequence 0001, 0010, 0100, 1000, 0001. data_out shows each channel's value (0x11, 0x22, 0x33, 0x44) one cycle after its grant.
- **Direct mode:** mode_in=0, sel_in=2, req_in=0110, data ch2=0xA5 → gnt_out=0100, then data_out=0xA5 and ch_out=2. With sel_in=3 and req_in[3]=0 → no grant and valid_out falls after accept.
- **Backpressure:** FULL with data_out=0x5A, ready_in=0 for 5 cycles while other channels request → gnt_out=0 and data_out stable. Set ready_in=1 → the next word is loaded in the same cycle and valid_out stays 1.
- **Wrap-around:** NUM_CH=4, last_ptr=3, req_in=1001 → channel 0 granted. Next, with req_in=1001 again → channel 3 granted.
- **Reset mid-transfer and illegal select:** FULL, then rst_in pulse → valid_out=0 and data_out=0 next cycle. Separately, NUM_CH=3 with sel_in=3 in direct mode → never granted.

Source files
------------

// File: rtl/minibyte_pkg.sv
// minibyte_pkg
// Shared definitions for the minibyte bus-multiplexer blocks.
//   MUX_MODE_DIRECT / MUX_MODE_RR : encodings of the arbitration mode input.
//   MAX_CH                        : largest supported channel count.
//   onehot()                      : index -> one-hot vector (MAX_CH bits wide;
//                                   callers slice to their channel count).
package minibyte_pkg;

  localparam logic MUX_MODE_DIRECT = 1'b0;
  localparam logic MUX_MODE_RR     = 1'b1;

  localparam int MAX_CH = 16;

  function automatic logic [MAX_CH-1:0] onehot(input logic [3:0] idx);
    logic [MAX_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/minibyte_rr_pick.sv
// minibyte_rr_pick
// Combinational rotate-priority picker. Searches req upward starting at the
// channel just after last_ptr, wrapping NUM_CH-1 -> 0, so last_ptr itself is
// examined last.
// Ports:
//   req      in  NUM_CH  per-channel request
//   last_ptr in  SEL_W   most recently served channel (< NUM_CH)
//   found    out 1       at least one channel requests
//   idx      out SEL_W   winning channel index (0 when !found)
module minibyte_rr_pick
  import minibyte_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = '0;
    // Offset 1 is the highest priority; offset NUM_CH lands back on last_ptr.
    for (int i = 1; i <= NUM_CH; i++) begin
      c = SEL_W'((int'(last_ptr) + i) % NUM_CH);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/minibyte_arbmux.sv
// minibyte_arbmux
// N-channel, WIDTH-bit registered bus multiplexer. Each cycle at most one
// requesting channel is granted (direct select or round-robin) and its word
// is captured into a one-entry output register drained by a valid/ready
// handshake. Accept and reload can happen on the same edge, giving one word
// per cycle under continuous demand.
// Ports:
//   clk_in    in  1             clock, rising edge
//   rst_in    in  1             synchronous active-high reset
//   mode_in   in  1             0 = direct select, 1 = round-robin
//   sel_in    in  SEL_W         channel index for direct mode
//   req_in    in  NUM_CH        per-channel request
//   data_in   in  NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   gnt_out   out NUM_CH        one-hot grant, high in the capture cycle
//   data_out  out WIDTH         registered selected word
//   ch_out    out SEL_W         channel that supplied data_out
//   valid_out out 1             data_out holds an unconsumed word
//   ready_in  in  1             consumer takes data_out this cycle
// NUM_CH is intended for 2..16.
module minibyte_arbmux
  import minibyte_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    mode_in,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_CH-1:0]       req_in,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]       gnt_out,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        ch_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  localparam int PAD_CH = 1 << SEL_W;

  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  ch_p1;
  logic              vld_p1;
  logic [SEL_W-1:0]  last_ptr;

  logic [PAD_CH-1:0] req_pad;
  logic              direct_found;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic              win_found;
  logic [SEL_W-1:0]  winner;
  logic              can_load;
  logic              load;
  logic [WIDTH-1:0]  win_data;
  logic [MAX_CH-1:0] win_oh;

  minibyte_rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req      (req_in),
    .last_ptr (last_ptr),
    .found    (rr_found),
    .idx      (rr_idx)
  );

  // Stage p0: winner selection, grant and data steering (combinational).
  // The request vector is zero-padded to a power of two so an out-of-range
  // sel_in (possible when NUM_CH is not a power of two) simply sees no request.
  always_comb begin
    req_pad              = '0;
    req_pad[NUM_CH-1:0]  = req_in;
    direct_found         = req_pad[sel_in];

    if (mode_in == MUX_MODE_RR) begin
      win_found = rr_found;
      winner    = rr_idx;
    end else begin
      win_found = direct_found;
      winner    = sel_in;
    end

    can_load = !vld_p1 || ready_in;
    load     = can_load && win_found && !rst_in;

    win_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (winner == SEL_W'(c)) begin
        win_data = data_in[c*WIDTH +: WIDTH];
      end
    end

    win_oh  = onehot(4'(winner));
    gnt_out = load ? win_oh[NUM_CH-1:0] : '0;
  end

  // Stage p1: one-entry output register with valid/ready handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ch_p1    <= '0;
      last_ptr <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      vld_p1   <= 1'b1;
      data_p1  <= win_data;
      ch_p1    <= winner;
      last_ptr <= winner;
    end else if (ready_in && vld_p1) begin
      vld_p1   <= 1'b0;
    end
  end

  assign data_out  = data_p1;
  assign ch_out    = ch_p1;
  assign valid_out = vld_p1;

endmodule

// File: tb/tb_minibyte_arbmux.sv
// tb_minibyte_arbmux
// Directed bench for minibyte_arbmux: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range direct select.
module tb_minibyte_arbmux;

  logic        clk;
  logic        rst;

  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic [1:0]  ch;
  logic        vld;
  logic        rdy;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  req3;
  logic [23:0] din3;
  logic [2:0]  gnt3;
  logic [7:0]  dout3;
  logic [1:0]  ch3;
  logic        vld3;
  logic        rdy3;

  int checks;
  int failures;

  minibyte_arbmux #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .mode_in   (mode),
    .sel_in    (sel),
    .req_in    (req),
    .data_in   (din),
    .gnt_out   (gnt),
    .data_out  (dout),
    .ch_out    (ch),
    .valid_out (vld),
    .ready_in  (rdy)
  );

  minibyte_arbmux #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk_in    (clk),
    .rst_in    (rst),
    .mode_in   (mode3),
    .sel_in    (sel3),
    .req_in    (req3),
    .data_in   (din3),
    .gnt_out   (gnt3),
    .data_out  (dout3),
    .ch_out    (ch3),
    .valid_out (vld3),
    .ready_in  (rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_gnt [5];
    logic [7:0] exp_dat [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rst  = 1'b1;
    mode = 1'b1;
    req  = 4'b1111;
    din  = {8'h44, 8'h33, 8'h22, 8'h11};
    rdy  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL reset_gnt cyc=%0d got=%b exp=0000", i, gnt);
      end
      checks++;
      if (vld !== 1'b0 || dout !== 8'h00 || ch !== 2'd0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d vld=%b data=%h ch=%0d exp vld=0 data=00 ch=0", i, vld, dout, ch);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gnt !== exp_gnt[i]) begin
        failures++;
        $display("FAIL rr_first_gnt n=%0d got=%b exp=%b", i, gnt, exp_gnt[i]);
      end
      step();
      checks++;
      if (vld !== 1'b1 || dout !== exp_dat[i] || ch !== 2'(i % 4)) begin
        failures++;
        $display("FAIL rr_first_data n=%0d vld=%b data=%h ch=%0d exp vld=1 data=%h ch=%0d",
                 i, vld, dout, ch, exp_dat[i], i % 4);
      end
      #1;
    end
  endtask

  task automatic test_direct();
    req = 4'b0000;
    step();
    checks++;
    if (vld !== 1'b0) begin
      failures++;
      $display("FAIL drain_valid got=%b exp=0", vld);
    end
    mode = 1'b0;
    sel  = 2'd2;
    req  = 4'b0110;
    din  = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL direct_gnt got=%b exp=0100", gnt);
    end
    step();
    checks++;
    if (vld !== 1'b1 || dout !== 8'hA5 || ch !== 2'd2) begin
      failures++;
      $display("FAIL direct_data vld=%b data=%h ch=%0d exp vld=1 data=a5 ch=2", vld, dout, ch);
    end
    sel = 2'd3;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL direct_noreq_gnt got=%b exp=0000", gnt);
    end
    step();
    checks++;
    if (vld !== 1'b0 || dout !== 8'hA5 || ch !== 2'd2) begin
      failures++;
      $display("FAIL direct_noreq_drain vld=%b data=%h ch=%0d exp vld=0 data=a5 ch=2", vld, dout, ch);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0;
    sel  = 2'd1;
    req  = 4'b0010;
    din  = {8'h44, 8'h33, 8'h5A, 8'h11};
    rdy  = 1'b1;
    step();
    checks++;
    if (vld !== 1'b1 || dout !== 8'h5A) begin
      failures++;
      $display("FAIL bp_load vld=%b data=%h exp vld=1 data=5a", vld, dout);
    end
    rdy  = 1'b0;
    mode = 1'b1;
    req  = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL bp_gnt cyc=%0d got=%b exp=0000", i, gnt);
      end
      step();
      checks++;
      if (vld !== 1'b1 || dout !== 8'h5A || ch !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d vld=%b data=%h ch=%0d exp vld=1 data=5a ch=1", i, vld, dout, ch);
      end
    end
    // last_ptr is 1, so channel 2 is next in round-robin order.
    rdy = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release_gnt got=%b exp=0100", gnt);
    end
    step();
    checks++;
    if (vld !== 1'b1 || dout !== 8'h33 || ch !== 2'd2) begin
      failures++;
      $display("FAIL bp_release_data vld=%b data=%h ch=%0d exp vld=1 data=33 ch=2", vld, dout, ch);
    end
  endtask

  task automatic test_wrap();
    mode = 1'b0;
    sel  = 2'd3;
    req  = 4'b1000;
    din  = {8'hC3, 8'h33, 8'h22, 8'h3C};
    step();
    checks++;
    if (ch !== 2'd3 || dout !== 8'hC3) begin
      failures++;
      $display("FAIL wrap_setup ch=%0d data=%h exp ch=3 data=c3", ch, dout);
    end
    mode = 1'b1;
    req  = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_gnt0 got=%b exp=0001", gnt);
    end
    step();
    checks++;
    if (ch !== 2'd0 || dout !== 8'h3C || vld !== 1'b1) begin
      failures++;
      $display("FAIL wrap_data0 ch=%0d data=%h vld=%b exp ch=0 data=3c vld=1", ch, dout, vld);
    end
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_gnt3 got=%b exp=1000", gnt);
    end
    step();
    checks++;
    if (ch !== 2'd3 || dout !== 8'hC3 || vld !== 1'b1) begin
      failures++;
      $display("FAIL wrap_data3 ch=%0d data=%h vld=%b exp ch=3 data=c3 vld=1", ch, dout, vld);
    end
  endtask

  task automatic test_back_to_back();
    // last_ptr is 3: continuous requests sweep 0,1,2,3 with no bubble.
    req = 4'b1111;
    din = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (vld !== 1'b1 || ch !== 2'(i) || dout !== 8'(8'hD1 + i)) begin
        failures++;
        $display("FAIL b2b n=%0d vld=%b ch=%0d data=%h exp vld=1 ch=%0d data=%h",
                 i, vld, ch, dout, i, 8'hD1 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    req = 4'b0000;
    step();
    checks++;
    if (vld !== 1'b1 || dout !== 8'hD4) begin
      failures++;
      $display("FAIL mid_full vld=%b data=%h exp vld=1 data=d4", vld, dout);
    end
    rst = 1'b1;
    req = 4'b1111;
    rdy = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst_gnt got=%b exp=0000", gnt);
    end
    step();
    checks++;
    if (vld !== 1'b0 || dout !== 8'h00 || ch !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_state vld=%b data=%h ch=%0d exp vld=0 data=00 ch=0", vld, dout, ch);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL mid_rst_first_gnt got=%b exp=0001", gnt);
    end
    step();
  endtask

  task automatic test_illegal_sel();
    mode3 = 1'b0;
    sel3  = 2'd3;
    req3  = 3'b111;
    din3  = {8'h73, 8'h72, 8'h71};
    rdy3  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt3 !== 3'b000) begin
        failures++;
        $display("FAIL illegal_sel_gnt cyc=%0d got=%b exp=000", i, gnt3);
      end
      step();
      checks++;
      if (vld3 !== 1'b0) begin
        failures++;
        $display("FAIL illegal_sel_valid cyc=%0d got=%b exp=0", i, vld3);
      end
    end
    sel3 = 2'd2;
    #1;
    checks++;
    if (gnt3 !== 3'b100) begin
      failures++;
      $display("FAIL legal_sel_gnt got=%b exp=100", gnt3);
    end
    step();
    checks++;
    if (vld3 !== 1'b1 || dout3 !== 8'h73 || ch3 !== 2'd2) begin
      failures++;
      $display("FAIL legal_sel_data vld=%b data=%h ch=%0d exp vld=1 data=73 ch=2", vld3, dout3, ch3);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    mode  = 1'b1;
    sel   = 2'd0;
    req   = 4'b0000;
    din   = '0;
    rdy   = 1'b0;
    mode3 = 1'b0;
    sel3  = 2'd0;
    req3  = 3'b000;
    din3  = '0;
    rdy3  = 1'b0;

    test_reset();
    test_direct();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_illegal_sel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
